// File: rtl/sda8fir.sv
// sda8fir: 8-tap signed FIR evaluated by serial distributed arithmetic.
// Each 9-clock frame loads one sample and then walks its 8 bit-planes LSB first.
module sda8fir #(
    parameter logic signed [7:0] C0 = 8'sd3,
    parameter logic signed [7:0] C1 = 8'sd10,
    parameter logic signed [7:0] C2 = 8'sd25,
    parameter logic signed [7:0] C3 = 8'sd40,
    parameter logic signed [7:0] C4 = 8'sd40,
    parameter logic signed [7:0] C5 = 8'sd25,
    parameter logic signed [7:0] C6 = 8'sd10,
    parameter logic signed [7:0] C7 = 8'sd3
) (
    input  logic        clk,
    input  logic        RstN,
    input  logic [7:0]  X,
    output logic [15:0] Yn
);

    localparam logic [63:0] COEFS = {C7, C6, C5, C4, C3, C2, C1, C0};

    function automatic logic signed [11:0] lut_entry(input logic [7:0] a);
        logic signed [11:0] s;
        logic signed [7:0]  c;
        s = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            c = COEFS[8*k +: 8];
            if (a[k]) s = s + 12'(c);
        end
        return s;
    endfunction

    // Constant ROM: entry a is the sum of the coefficients whose tap bit is set in a.
    logic signed [11:0] lut [256];
    for (genvar a = 0; a < 256; a++) begin : g_lut
        assign lut[a] = lut_entry(8'(a));
    end

    logic [3:0]         cnt;
    logic [7:0]         xd [8];
    logic [7:0]         sr [8];
    logic signed [19:0] acc;
    logic signed [19:0] term;
    logic signed [19:0] next_acc;
    logic [7:0]         addr;
    logic [2:0]         bsel;

    always_comb begin
        addr = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            addr[k] = sr[k][0];
        end
        bsel = 3'(cnt - 4'd1);
        term = 20'(lut[addr]) <<< bsel;
        // Bit-plane 7 carries negative weight in two's complement.
        if (bsel == 3'd7) begin
            next_acc = acc - term;
        end else begin
            next_acc = acc + term;
        end
    end

    always_ff @(posedge clk or posedge RstN) begin
        if (RstN) begin
            cnt <= '0;
            acc <= '0;
            Yn  <= '0;
            for (int unsigned k = 0; k < 8; k++) begin
                xd[k] <= '0;
                sr[k] <= '0;
            end
        end else if (cnt == 4'd0) begin
            xd[0] <= X;
            sr[0] <= X;
            for (int unsigned k = 1; k < 8; k++) begin
                xd[k] <= xd[k-1];
                sr[k] <= xd[k-1];
            end
            acc <= '0;
            cnt <= 4'd1;
        end else begin
            acc <= next_acc;
            for (int unsigned k = 0; k < 8; k++) begin
                sr[k] <= {1'b0, sr[k][7:1]};
            end
            if (cnt == 4'd8) begin
                Yn  <= next_acc[15:0];
                cnt <= '0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_sda8fir.sv
// Directed and table-driven checks for sda8fir, framing stimulus in 9-clock frames.
module tb_sda8fir;

    logic        clk;
    logic        RstN;
    logic [7:0]  X;
    logic [15:0] Yn;

    int ncmp;
    int nfail;
    int hist [8];
    int coef [8] = '{3, 10, 25, 40, 40, 25, 10, 3};

    typedef struct {
        int x;
        int y;
    } vec_t;

    vec_t vt[$];

    sda8fir #(
        .C0(8'sd3), .C1(8'sd10), .C2(8'sd25), .C3(8'sd40),
        .C4(8'sd40), .C5(8'sd25), .C6(8'sd10), .C7(8'sd3)
    ) dut (
        .clk (clk),
        .RstN(RstN),
        .X   (X),
        .Yn  (Yn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    function automatic void model_clear();
        for (int k = 0; k < 8; k++) hist[k] = 0;
    endfunction

    function automatic logic [15:0] model_step(input int x);
        int s;
        for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = x;
        s = 0;
        for (int k = 0; k < 8; k++) s += coef[k] * hist[k];
        return 16'(s);
    endfunction

    // Called at a negedge just before a load edge; returns at the negedge after Yn updates.
    task automatic run_frame(input int xv, input bit glitch, input int junk);
        X = 8'(xv);
        repeat (3) @(posedge clk);
        if (glitch) begin
            @(negedge clk);
            X = 8'(junk);
        end
        repeat (6) @(posedge clk);
        @(negedge clk);
    endtask

    function automatic void add(input int x, input int y);
        vec_t v;
        v.x = x;
        v.y = y;
        vt.push_back(v);
    endfunction

    initial begin
        logic [15:0] exp;
        int xs;
        ncmp  = 0;
        nfail = 0;

        add(1, 3);    add(0, 10);   add(0, 25);   add(0, 40);   add(0, 40);
        add(0, 25);   add(0, 10);   add(0, 3);    add(0, 0);
        add(-1, -3);  add(0, -10);  add(0, -25);  add(0, -40);  add(0, -40);
        add(0, -25);  add(0, -10);  add(0, -3);   add(0, 0);
        add(127, 381);    add(127, 1651);   add(127, 4826);   add(127, 9906);
        add(127, 14986);  add(127, 18161);  add(127, 19431);  add(127, 19812);
        add(127, 19812);
        add(-128, 19047);  add(-128, 16497);  add(-128, 10122);  add(-128, -78);
        add(-128, -10278); add(-128, -16653); add(-128, -19203); add(-128, -19968);
        add(-128, -19968);

        // Reset held for 50 time units with random input.
        RstN = 1'b1;
        X    = 8'($urandom);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            X = 8'($urandom);
            check("reset_hold", Yn, 16'd0);
        end
        RstN = 1'b0;
        X    = 8'd0;
        model_clear();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("post_reset_zero", Yn, 16'd0);
        end

        for (int i = 0; i < vt.size(); i++) begin
            run_frame(vt[i].x, 1'b0, 0);
            exp = model_step(vt[i].x);
            check($sformatf("table[%0d]", i), Yn, 16'(vt[i].y));
        end

        // Mid-frame reset after three frames of 50.
        for (int i = 0; i < 3; i++) begin
            run_frame(50, 1'b0, 0);
            exp = model_step(50);
            check("pre_reset_50", Yn, exp);
        end
        X = 8'd50;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("before_midreset", Yn, exp);
        RstN = 1'b1;
        #1;
        check("midreset_immediate", Yn, 16'd0);
        @(negedge clk);
        check("midreset_hold", Yn, 16'd0);
        X    = 8'd0;
        RstN = 1'b0;
        model_clear();
        for (int i = 0; i < 9; i++) begin
            run_frame(0, 1'b0, 0);
            check("no_residue", Yn, 16'd0);
        end

        // Random samples with X disturbed mid-frame.
        for (int i = 0; i < 176; i++) begin
            xs = $signed(8'($urandom));
            run_frame(xs, 1'b1, int'($urandom_range(0, 255)));
            exp = model_step(xs);
            check($sformatf("rand[%0d]", i), Yn, exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
